// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and default widths
// (the default widths are also the ones the mul4x4 round-trip bench uses).
package seq_divider_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_VW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then subtract the divisor if the result stays non-negative.
module div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW-1:0] i_r,
  input  logic          i_q_msb,
  input  logic [VW-1:0] i_d,
  output logic [VW-1:0] o_r,
  output logic          o_qbit
);

  logic [VW:0] w_t;
  logic [VW:0] w_diff;
  logic [VW:0] w_res;
  logic        w_unused_msb;

  // The trial value is one bit wider than the divisor, so the compare cannot overflow.
  assign w_t          = {i_r, i_q_msb};
  assign w_diff       = w_t - {1'b0, i_d};
  assign o_qbit       = (w_t >= {1'b0, i_d});
  assign w_res        = o_qbit ? w_diff : w_t;
  // The restored partial remainder is always below 2^VW, so the top bit is always zero.
  assign o_r          = w_res[VW-1:0];
  assign w_unused_msb = w_res[VW];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake;
// one quotient bit per clock, DW clocks per division.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  div_state_e    r_state;
  div_state_e    w_state_d;
  logic [DW-1:0] r_q;
  logic [VW-1:0] r_d;
  logic [VW-1:0] r_r;
  logic [CW-1:0] r_cnt;
  logic          r_dz;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem;
  logic          r_dz_out;
  logic [VW-1:0] w_r_next;
  logic          w_qbit;
  logic [DW-1:0] w_q_next;
  logic          w_accept;
  logic          w_last;

  div_step #(
    .VW(VW)
  ) u_step (
    .i_r    (r_r),
    .i_q_msb(r_q[DW-1]),
    .i_d    (r_d),
    .o_r    (w_r_next),
    .o_qbit (w_qbit)
  );

  assign w_q_next = {r_q[DW-2:0], w_qbit};
  assign w_accept = start && (r_state != StRun);
  assign w_last   = (r_state == StRun) && (r_cnt == '0);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: w_state_d = start ? StRun : StIdle;
      StRun:          w_state_d = (r_cnt == '0) ? StDone : StRun;
      default:        w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_q      <= '0;
      r_d      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_dz     <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz_out <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_q   <= dividend;
        r_d   <= divisor;
        r_r   <= '0;
        r_cnt <= CW'(DW - 1);
        r_dz  <= (divisor == '0);
      end else if (r_state == StRun) begin
        r_q   <= w_q_next;
        r_r   <= w_r_next;
        r_cnt <= r_cnt - 1'b1;
      end
      // Divide-by-zero overrides whatever the iterations produced.
      if (w_last) begin
        r_quot   <= r_dz ? '1 : w_q_next;
        r_rem    <= r_dz ? '0 : w_r_next;
        r_dz_out <= r_dz;
      end
    end
  end

  assign busy        = (r_state == StRun);
  assign done        = (r_state == StDone);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: accepted starts push expected results,
// a negedge monitor pops and checks them (values and latency) on every done.
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  seq_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    int q;
    int r;
    int dz;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   free_at  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and record the start if the
  // reference model says the divider was free to take it.
  task automatic step(input logic s, input int a, input int b);
    exp_t e;
    start    = s;
    dividend = DW'(a);
    divisor  = VW'(b);
    @(posedge clk);
    #1;
    if (s && rst_n && edge_cnt >= free_at) begin
      e.dz  = (b == 0) ? 1 : 0;
      e.q   = (b == 0) ? (1 << DW) - 1 : a / b;
      e.r   = (b == 0) ? 0 : a % b;
      e.due = edge_cnt + DW;
      sb.push_back(e);
      free_at = edge_cnt + DW + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_latency", edge_cnt, e.due);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dz);
        end
      end else if (sb.size() != 0 && edge_cnt >= sb[0].due) begin
        chk("missing_done", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int nbusy;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32/8 with busy-width measurement.
    step(1'b1, 32, 8);
    nbusy = 0;
    for (int i = 0; i < 11; i++) begin
      nbusy += int'(busy);
      step(1'b0, 0, 0);
    end
    chk("busy_cycles", nbusy, DW);
    chk("hold_quotient", int'(quotient), 4);

    step(1'b1, 200, 7);  idle(10);
    step(1'b1, 255, 1);  idle(10);
    step(1'b1, 3, 15);   idle(10);
    step(1'b1, 91, 0);   idle(10);
    step(1'b1, 15, 3);   idle(10);

    // Start while busy is ignored.
    step(1'b1, 100, 9);
    idle(2);
    step(1'b1, 50, 5);
    idle(10);

    // Start held through DONE; inputs switch to 15/3 in the DONE cycle.
    for (int i = 0; i <= DW; i++) step(1'b1, 200, 7);
    step(1'b1, 15, 3);
    idle(10);

    // Asynchronous reset in busy cycle 4.
    step(1'b1, 200, 7);
    idle(3);
    #3;
    rst_n = 1'b0;
    sb.delete();
    free_at = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dz", int'(div_by_zero), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(12);
    step(1'b1, 32, 8);
    idle(10);

    // Random traffic, including starts that land while busy.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)));
    end
    idle(12);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
